// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge-event arbiter: FSM encoding, the channel-count
// ceiling and the round-robin selector.
package edge_evt_pkg;

    typedef enum logic {IDLE, PRESENT} fsm_t;

    localparam int MAX_CH = 16;

    // Returns the first set bit at or after ptr, wrapping modulo n (n <= MAX_CH, ptr < n).
    function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] pend,
                                           input logic [3:0]        ptr,
                                           input int unsigned       n);
        logic [4:0] idx;
        logic       found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (k < int'(n)) begin
                idx = {1'b0, ptr} + 5'(k);
                if (idx >= 5'(n)) idx = idx - 5'(n);
                if (!found && pend[idx[3:0]]) begin
                    rr_pick = idx[3:0];
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/edgedet_bank.sv
// NUM_CH parallel edge detectors with per-channel history.
// Defining EDGE_EVT_SYNC_EN inserts a 2-flop synchronizer in front of each detector.
module edgedet_bank #(
    parameter int NUM_CH      = 4,
    parameter int RISING_EDGE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] lvl_i,
    output logic [NUM_CH-1:0] det_o
);

    logic [NUM_CH-1:0] lvl;
    logic [NUM_CH-1:0] prev_q;

`ifdef EDGE_EVT_SYNC_EN
    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;

    // Synchronizer runs every cycle; en only gates the history and the detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= lvl_i;
            sync2_q <= sync1_q;
        end
    end

    assign lvl = sync2_q;
`else
    assign lvl = lvl_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else if (en_i) begin
            prev_q <= lvl;
        end
    end

    always_comb begin
        det_o = '0;
        if (en_i) begin
            det_o = (RISING_EDGE != 0) ? (~prev_q & lvl) : (prev_q & ~lvl);
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: latches detected edges as pending events and presents them one at a
// time on a valid/ready port in round-robin order. Optional input sync: EDGE_EVT_SYNC_EN.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int RISING_EDGE = 1,
    parameter int CH_W        = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] i,
    output logic              o_valid,
    output logic [CH_W-1:0]   o_ch,
    input  logic              o_ready,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] ovr,
    input  logic [NUM_CH-1:0] ovr_clr
);

    fsm_t              state_q, state_d;
    logic [CH_W-1:0]   och_q, och_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] ovr_q, ovr_d;
    logic [NUM_CH-1:0] det;
    logic [NUM_CH-1:0] xfer_vec;
    logic [MAX_CH-1:0] pend_ext;
    logic              xfer;

    edgedet_bank #(
        .NUM_CH      (NUM_CH),
        .RISING_EDGE (RISING_EDGE)
    ) u_det (
        .clk   (clk),
        .rst   (rst),
        .en_i  (en),
        .lvl_i (i),
        .det_o (det)
    );

    assign xfer     = (state_q == PRESENT) && o_ready;
    assign xfer_vec = xfer ? (NUM_CH'(1) << och_q) : '0;

    // A fresh edge on the channel being transferred re-arms pending instead of overrunning.
    assign pend_d = (pend_q & ~xfer_vec) | det;
    assign ovr_d  = (ovr_q & ~ovr_clr) | (det & pend_q & ~xfer_vec);

    always_comb begin
        pend_ext               = '0;
        pend_ext[NUM_CH-1:0]   = pend_q;
    end

    always_comb begin
        state_d = state_q;
        och_d   = och_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    och_d   = CH_W'(rr_pick(pend_ext, 4'(rr_q), NUM_CH));
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (o_ready) begin
                    rr_d    = (och_q == CH_W'(NUM_CH - 1)) ? '0 : och_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            och_q   <= '0;
            rr_q    <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            och_q   <= och_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_valid = (state_q == PRESENT);
    assign o_ch    = och_q;
    assign pending = pend_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios plus random traffic,
// compared every cycle against an event-level reference model.
module tb_edge_event_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] i;
    logic         o_valid;
    logic [1:0]   o_ch;
    logic         o_ready;
    logic [N-1:0] pending;
    logic [N-1:0] ovr;
    logic [N-1:0] ovr_clr;

    logic         f_valid;
    logic [1:0]   f_ch;
    logic         f_ready;
    logic [N-1:0] f_pending;
    logic [N-1:0] f_ovr;

    int total = 0;
    int bad   = 0;

    edge_event_arbiter #(.NUM_CH(N), .RISING_EDGE(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .i       (i),
        .o_valid (o_valid),
        .o_ch    (o_ch),
        .o_ready (o_ready),
        .pending (pending),
        .ovr     (ovr),
        .ovr_clr (ovr_clr)
    );

    edge_event_arbiter #(.NUM_CH(N), .RISING_EDGE(0)) dut_f (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .i       (i),
        .o_valid (f_valid),
        .o_ch    (f_ch),
        .o_ready (f_ready),
        .pending (f_pending),
        .ovr     (f_ovr),
        .ovr_clr (ovr_clr)
    );

    always #5 clk = ~clk;

    // Reference model of the rising-edge instance.
    bit m_prev[N];
    bit m_pend[N];
    bit m_ovr[N];
    bit m_pres;
    int m_ch;
    int m_rr;
    int grants[$];

    function automatic logic [N-1:0] mpack(input bit a[N]);
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = a[c];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_prev[c] = 1'b0;
            m_pend[c] = 1'b0;
            m_ovr[c]  = 1'b0;
        end
        m_pres = 1'b0;
        m_ch   = 0;
        m_rr   = 0;
    endtask

    // Applies the currently driven inputs as the next clock edge would.
    task automatic model_step();
        bit old_pend[N];
        bit det;
        bit this_x;
        bit xf;
        xf       = m_pres && o_ready;
        old_pend = m_pend;
        for (int c = 0; c < N; c++) begin
            this_x = xf && (c == m_ch);
            det    = en && !m_prev[c] && i[c];
            if (det && old_pend[c] && !this_x) m_ovr[c] = 1'b1;
            else if (ovr_clr[c])               m_ovr[c] = 1'b0;
            if (det)         m_pend[c] = 1'b1;
            else if (this_x) m_pend[c] = 1'b0;
            if (en) m_prev[c] = i[c];
        end
        if (m_pres) begin
            if (o_ready) begin
                m_pres = 1'b0;
                m_rr   = (m_ch + 1) % N;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!m_pres && old_pend[(m_rr + k) % N]) begin
                    m_ch   = (m_rr + k) % N;
                    m_pres = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("o_valid", 32'(o_valid), 32'(m_pres));
        chk("o_ch",    32'(o_ch),    32'(m_ch));
        chk("pending", 32'(pending), 32'(mpack(m_pend)));
        chk("ovr",     32'(ovr),     32'(mpack(m_ovr)));
    endtask

    task automatic tick();
        model_step();
        if (o_valid && o_ready) grants.push_back(int'(o_ch));
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid",   32'(o_valid), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ovr",     32'(ovr),     32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_grants(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp[4];
        exp = '{e0, e1, e2, e3};
        chk({tag, "_count"}, 32'(grants.size()), 32'd4);
        for (int k = 0; k < grants.size() && k < 4; k++) chk(tag, 32'(grants[k]), 32'(exp[k]));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; i = '0; o_ready = 1'b0; ovr_clr = '0; f_ready = 1'b0;
        model_reset();
        #12;
        check_all();

        // Channel held high at reset release produces exactly one event.
        @(negedge clk);
        rst = 1'b0; en = 1'b1; i = 4'b0010; o_ready = 1'b1;
        tick();
        chk("first_pending", 32'(pending), 32'h2);
        tick();
        chk("first_valid", 32'(o_valid), 32'd1);
        chk("first_ch",    32'(o_ch),    32'd1);
        tick();
        chk("first_drain", 32'(pending), 32'd0);

        // Simultaneous edges from rr_ptr=0 then rr_ptr=2.
        @(negedge clk); do_reset();
        i = 4'b0000; tick();
        grants.delete();
        i = 4'b1111;
        for (int k = 0; k < 9; k++) tick();
        chk_grants("order_rr0", 0, 1, 2, 3);
        i = 4'b0000; tick();
        i = 4'b0010; tick(); tick(); tick();
        i = 4'b0000; tick();
        grants.delete();
        i = 4'b1111;
        for (int k = 0; k < 9; k++) tick();
        chk_grants("order_rr2", 2, 3, 0, 1);

        // Presented channel holds while a new edge arrives elsewhere.
        @(negedge clk); do_reset();
        o_ready = 1'b0; i = 4'b0000; tick();
        i = 4'b1000; tick(); tick();
        i = 4'b1010; tick(); tick();
        chk("hold_ch", 32'(o_ch), 32'd3);
        o_ready = 1'b1; tick(); tick();
        chk("next_ch", 32'(o_ch), 32'd1);
        tick();

        // Overrun on ch2, clear, and clear coincident with a new overrun.
        o_ready = 1'b0; i = 4'b0000; tick();
        i = 4'b0100; tick();
        i = 4'b0000; tick();
        i = 4'b0100; tick();
        chk("ovr_set", 32'(ovr[2]), 32'd1);
        ovr_clr = 4'b0100; tick(); ovr_clr = '0;
        chk("ovr_clr", 32'(ovr[2]), 32'd0);
        i = 4'b0000; tick();
        i = 4'b0100; ovr_clr = 4'b0100; tick(); ovr_clr = '0;
        chk("ovr_set_wins", 32'(ovr[2]), 32'd1);
        grants.delete();
        o_ready = 1'b1; tick(); tick(); tick();
        chk("ovr_one_event", 32'(grants.size()), 32'd1);
        ovr_clr = 4'b1111; tick(); ovr_clr = '0;

        // Edge on ch0 in the cycle ch0 transfers.
        o_ready = 1'b0; i = 4'b0000; tick();
        i = 4'b0001; tick(); tick();
        i = 4'b0000; tick();
        i = 4'b0001; o_ready = 1'b1; tick();
        chk("reedge_pending", 32'(pending[0]), 32'd1);
        chk("reedge_ovr",     32'(ovr[0]),     32'd0);
        tick();
        chk("reedge_valid", 32'(o_valid), 32'd1);
        tick();

        // en=0 freezes detection.
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i = 4'(k * 5 + 3);
            tick();
        end
        chk("en0_pending", 32'(pending), 32'd0);
        en = 1'b1;

        // Async reset mid-PRESENT.
        o_ready = 1'b0; i = 4'b0000; tick();
        i = 4'b0100; tick(); tick();
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        #2;
        do_reset();

        // Falling-edge instance.
        i = 4'b0010; tick();
        chk("fall_none", 32'(f_pending), 32'd0);
        i = 4'b0000; tick();
        chk("fall_pending", 32'(f_pending), 32'h2);
        tick();
        chk("fall_valid", 32'(f_valid), 32'd1);
        chk("fall_ch",    32'(f_ch),    32'd1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            en      = ($urandom_range(0, 3) != 0);
            i       = i ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            o_ready = ($urandom_range(0, 2) != 0);
            ovr_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : '0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
